// File: rtl/system_moore_pkg.sv
// Shared definitions for the multi-channel Moore request/confirm system.
// State codes, state width and timeout counter width.
package system_moore_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    WAIT    = 3'd2,
    WRITE   = 3'd3,
    ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/channel_reg.sv
// One output channel: WIDTH-bit register with load enable.
// Asynchronous active-low reset clears it to zero.
module channel_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/system_moore_multi.sv
// Moore request/confirm FSM committing a held word into round-robin
// channels, with confirm timeout, cancel and debug outputs.
module system_moore_multi #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 15,
  localparam int PTR_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      request,
  input  logic                      confirm,
  input  logic                      cancel,
  input  logic [WIDTH-1:0]          din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       wr_en,
  output logic [PTR_W-1:0]          ptr,
  output logic [2:0]                state,
  output logic                      busy,
  output logic                      err
);

  import system_moore_pkg::*;

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nx;
  logic             w_load;
  logic             w_commit;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CHANNELS - 1);

  always_comb begin
    w_next   = r_state;
    w_cnt_nx = r_cnt;
    unique case (r_state)
      IDLE:    if (request) w_next = CAPTURE;
      CAPTURE: begin
        w_cnt_nx = '0;
        w_next   = WAIT;
      end
      WAIT: begin
        if (cancel)                w_next = IDLE;
        else if (confirm)          w_next = WRITE;
        else if (r_cnt == CNT_LAST) w_next = ERR;
        else                       w_cnt_nx = r_cnt + 1'b1;
      end
      WRITE:   w_next = IDLE;
      ERR:     if (!request) w_next = IDLE;
      // codes 5..7 fall back to IDLE
      default: w_next = IDLE;
    endcase
  end

  assign w_load   = (r_state == IDLE) && request;
  assign w_commit = (r_state == WRITE);
  assign w_ptr_nx = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      if (w_load)   r_hold <= din;
      if (w_commit) r_ptr  <= w_ptr_nx;
    end
  end

  assign wr_en = w_commit ? (CHANNELS'(1) << r_ptr) : '0;
  assign ptr   = r_ptr;
  assign state = r_state;
  assign busy  = (r_state != IDLE);
  assign err   = (r_state == ERR);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    channel_reg #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst),
      .i_en  (wr_en[k]),
      .i_d   (r_hold),
      .o_q   (dout[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_system_moore_multi.sv
// Directed bench: default instance plus an 8-bit/3-channel/timeout-2
// instance, checked against hand-computed values.
module tb_system_moore_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_cfm, a_can;
  logic [3:0]  a_din;
  logic [15:0] a_dout;
  logic [3:0]  a_wr;
  logic [1:0]  a_ptr;
  logic [2:0]  a_st;
  logic        a_busy, a_err;

  logic        b_req, b_cfm, b_can;
  logic [7:0]  b_din;
  logic [23:0] b_dout;
  logic [2:0]  b_wr;
  logic [1:0]  b_ptr;
  logic [2:0]  b_st;
  logic        b_busy, b_err;

  system_moore_multi u_a (
    .clk     (clk),
    .rst     (rst),
    .request (a_req),
    .confirm (a_cfm),
    .cancel  (a_can),
    .din     (a_din),
    .dout    (a_dout),
    .wr_en   (a_wr),
    .ptr     (a_ptr),
    .state   (a_st),
    .busy    (a_busy),
    .err     (a_err)
  );

  system_moore_multi #(
    .WIDTH    (8),
    .CHANNELS (3),
    .TIMEOUT  (2)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .request (b_req),
    .confirm (b_cfm),
    .cancel  (b_can),
    .din     (b_din),
    .dout    (b_dout),
    .wr_en   (b_wr),
    .ptr     (b_ptr),
    .state   (b_st),
    .busy    (b_busy),
    .err     (b_err)
  );

  int errs   = 0;
  int checks = 0;
  int busy_cnt;
  int wr_cnt;
  logic [3:0] wr_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_busy) busy_cnt++;
    if (a_wr != '0) begin
      wr_cnt++;
      wr_seen = a_wr;
    end
  endtask

  task automatic commit_a(input logic [3:0] d, input int waits);
    a_din = d;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    tick();
    repeat (waits) tick();
    a_cfm = 1'b1;
    tick();
    a_cfm = 1'b0;
    tick();
  endtask

  task automatic commit_b(input logic [7:0] d);
    b_din = d;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    tick();
    b_cfm = 1'b1;
    tick();
    b_cfm = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_req = 0; a_cfm = 0; a_can = 0; a_din = '0;
    b_req = 0; b_cfm = 0; b_can = 0; b_din = '0;
    busy_cnt = 0; wr_cnt = 0; wr_seen = '0;

    #12;
    chk("rst_dout", 32'(a_dout), 32'h0);
    chk("rst_ptr",  32'(a_ptr),  32'h0);
    chk("rst_st",   32'(a_st),   32'h0);
    chk("rst_wr",   32'(a_wr),   32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_err",  32'(a_err),  32'h0);
    chk("rst_bdout", 32'(b_dout), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    busy_cnt = 0; wr_cnt = 0;
    commit_a(4'hA, 1);
    chk("c1_dout",  32'(a_dout), 32'h000A);
    chk("c1_ptr",   32'(a_ptr),  32'h1);
    chk("c1_busy",  busy_cnt,    32'd4);
    chk("c1_wrcnt", wr_cnt,      32'd1);
    chk("c1_wrval", 32'(wr_seen), 32'h1);
    chk("c1_st",    32'(a_st),   32'h0);

    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) commit_a(4'(i), 0);
    chk("rr_dout", 32'(a_dout), 32'h4325);
    chk("rr_ptr",  32'(a_ptr),  32'h1);

    a_din = 4'h7;
    a_req = 1'b1;
    tick();
    chk("to_cap", 32'(a_st), 32'h1);
    tick();
    chk("to_wait", 32'(a_st), 32'h2);
    repeat (14) tick();
    chk("to_14st",  32'(a_st),  32'h2);
    chk("to_14err", 32'(a_err), 32'h0);
    tick();
    chk("to_15st",  32'(a_st),  32'h4);
    chk("to_15err", 32'(a_err), 32'h1);
    tick();
    chk("to_hold", 32'(a_st), 32'h4);
    a_req = 1'b0;
    tick();
    chk("to_idle", 32'(a_st),   32'h0);
    chk("to_err0", 32'(a_err),  32'h0);
    chk("to_dout", 32'(a_dout), 32'h4325);
    chk("to_ptr",  32'(a_ptr),  32'h1);

    wr_cnt = 0;
    a_din = 4'hF;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    tick();
    chk("cx_wait", 32'(a_st), 32'h2);
    a_cfm = 1'b1;
    a_can = 1'b1;
    tick();
    chk("cx_idle", 32'(a_st), 32'h0);
    a_cfm = 1'b0;
    a_can = 1'b0;
    tick();
    chk("cx_wr",   wr_cnt,      32'd0);
    chk("cx_ptr",  32'(a_ptr),  32'h1);
    chk("cx_dout", 32'(a_dout), 32'h4325);

    a_din = 4'h9;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    tick();
    a_cfm = 1'b1;
    tick();
    chk("mr_write", 32'(a_st), 32'h3);
    chk("mr_wren",  32'(a_wr), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_st",   32'(a_st),   32'h0);
    chk("mr_dout", 32'(a_dout), 32'h0);
    chk("mr_wr",   32'(a_wr),   32'h0);
    chk("mr_ptr",  32'(a_ptr),  32'h0);
    a_cfm = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    commit_b(8'hFF);
    commit_b(8'h01);
    commit_b(8'h80);
    chk("p_dout", 32'(b_dout), 32'h8001FF);
    chk("p_ptr",  32'(b_ptr),  32'h0);

    b_din = 8'h33;
    b_req = 1'b1;
    tick();
    tick();
    chk("p_wait", 32'(b_st), 32'h2);
    tick();
    chk("p_1st", 32'(b_st), 32'h2);
    tick();
    chk("p_2st",  32'(b_st),  32'h4);
    chk("p_2err", 32'(b_err), 32'h1);
    b_req = 1'b0;
    tick();
    chk("p_idle",  32'(b_st),   32'h0);
    chk("p_dout2", 32'(b_dout), 32'h8001FF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/system_moore_multi.md
Name: system_moore_multi

Overview:
- Parametrised successor to the two-register Moore request/confirm system.
- A Moore FSM captures an input word on `request` and holds it until `confirm` arrives. It then commits the word into one of CHANNELS output registers, chosen round-robin.
- Adds three features: a confirm timeout with an error state, a `cancel` input, and a visible write-enable vector and channel pointer for debug and lab display.

Parameters:
- WIDTH, 4, data word width in bits.
- CHANNELS, 4, number of output registers; legal range 2..16.
- TIMEOUT, 15, number of clock cycles to wait for `confirm` before entering ERR; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- request  input  1  asks the block to capture `din`.
- confirm  input  1  approves the commit of the captured word.
- cancel  input  1  drops the captured word; has priority over `confirm`.
- din  input  WIDTH  data word to capture.
- dout  output  CHANNELS*WIDTH  flattened channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
- wr_en  output  CHANNELS  one-hot write strobe; all zero except in WRITE.
- ptr  output  clog2(CHANNELS)  channel that the next commit will write.
- state  output  3  current FSM state encoding.
- busy  output  1  high in any state except IDLE.
- err  output  1  high only in ERR.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE, holding register=0, all `dout` channels=0, ptr=0, timeout counter=0.
  - `wr_en`=0, `busy`=0, `err`=0.
  - Reset asserted mid-operation aborts the transaction immediately; the captured word is lost.
- All outputs are Moore outputs, decoded from registered state and registers only. No input reaches an output combinationally.
- State encodings: IDLE=0, CAPTURE=1, WAIT=2, WRITE=3, ERR=4. Codes 5..7 are illegal and recover to IDLE on the next edge.
- IDLE:
  - `request`=1 -> CAPTURE; the holding register loads `din` on the same edge.
  - Otherwise stay in IDLE.
- CAPTURE: lasts one cycle. Clears the timeout counter, then -> WAIT unconditionally.
- WAIT: evaluated in this priority order.
  - `cancel`=1 -> IDLE; the holding register is left unchanged and no write occurs.
  - Else `confirm`=1 -> WRITE.
  - Else if counter == TIMEOUT-1 -> ERR.
  - Else counter increments.
  - `request` is ignored in WAIT; a new `din` is not captured.
- WRITE: lasts one cycle.
  - `wr_en`[ptr]=1.
  - On the exit edge: channel[ptr] <= holding register; ptr <= (ptr+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - -> IDLE.
- ERR:
  - Stays in ERR while `request`=1.
  - `request`=0 -> IDLE; err clears on that edge.
  - No channel is modified.
- Latency:
  - `request` sampled at edge n gives CAPTURE in cycle n..n+1 and WAIT from edge n+1.
  - `confirm` sampled at edge m gives WRITE during cycle m..m+1; `dout` is updated at edge m+1.
  - Minimum cycle count from request to updated `dout` is 3 edges.
- Timeout: with no `confirm`, ERR is entered exactly TIMEOUT edges after WAIT is entered.
- `confirm` and `cancel` asserted together: `cancel` wins.
- Channels not addressed by a write hold their value indefinitely.

Decomposition:
- Shared package `system_moore_pkg`:
  - State encoding localparams IDLE..ERR, and STATE_W=3.
  - A clog2 helper function, if the toolchain needs one.
- Sub-module `channel_reg`:
  - Parametrised WIDTH register with enable and asynchronous active-low reset.
  - Instantiated CHANNELS times via a generate loop, each enabled by `wr_en`[k].
  - The FSM, timeout counter, holding register and ptr stay in the top module.

Test Plan:
- Reset/basic commit (defaults): `rst` low, then high.
  - Expect all `dout`=0, ptr=0.
  - Then request with `din`=4'hA, confirm 2 cycles later.
  - Expect channel0=4'hA, ptr=1, `wr_en` pulse 4'b0001 for exactly one cycle, `busy` high for 4 cycles.
- Round-robin wrap: five commits with `din`=1,2,3,4,5.
  - Expect channels [0..3] = 5,2,3,4 and ptr=1.
- Timeout: request `din`=4'h7 and never confirm.
  - Expect `err`=1 exactly 15 edges after WAIT is entered, and no channel changed.
  - Drop `request`: expect IDLE next edge and `err`=0.
- Cancel priority: in WAIT, assert `confirm` and `cancel` together.
  - Expect IDLE, `wr_en` never asserted, ptr unchanged.
- Reset mid-operation: assert `rst` low asynchronously (between edges) while in WRITE.
  - Expect state=0, all channels=0 and `wr_en`=0 immediately, without waiting for an edge.
- Parametrisation: WIDTH=8, CHANNELS=3, TIMEOUT=2.
  - Three commits of 8'hFF, 8'h01, 8'h80 give `dout`={8'h80,8'h01,8'hFF} and ptr=0.
  - An unconfirmed request reaches ERR after 2 edges.
